// File: rtl/hilo_divu_pkg.sv
// rtl/hilo_divu_pkg.sv - shared constants and state encoding for the HI/LO divide controller
package hilo_divu_pkg;

  localparam int FUNCT_W = 6;

  // MIPS funct codes seen from EX, and divider command codes.
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU = 6'b011011;
  localparam logic [FUNCT_W-1:0] FUNCT_MFHI = 6'b010000;
  localparam logic [FUNCT_W-1:0] FUNCT_MTHI = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MFLO = 6'b010010;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO = 6'b010011;
  localparam logic [FUNCT_W-1:0] SIG_PAUSE  = 6'b000000;
  // Divider read-out command; this controller never issues it, it samples
  // div_dataOut directly on the capture cycle instead.
  localparam logic [FUNCT_W-1:0] SIG_OUT    = 6'b111111;

  // Default divider timing: 1 load + 33 iterations, result sampled at 36.
  localparam int DIV_ISSUE_CYCLES_DEF = 34;
  localparam int DIV_RESULT_CYCLE_DEF = 36;
  localparam int CNT_W_DEF            = 6;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_e;

endpackage

// File: rtl/hilo_divu_if.sv
// rtl/hilo_divu_if.sv - EX-stage and divider signal bundle for the HI/LO controller
// slave  : controller side (takes EX op + divider result, drives divider and stall/mf_data)
// master : environment side (EX stage + divider)
import hilo_divu_pkg::*;

interface hilo_divu_if;
  logic               op_valid;
  logic [FUNCT_W-1:0] funct;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;
  logic               flush;
  logic               stall;
  logic [31:0]        mf_data;
  logic [FUNCT_W-1:0] div_signal;
  logic [31:0]        div_dataA;
  logic [31:0]        div_dataB;
  logic               div_rst;
  logic [63:0]        div_dataOut;

  modport slave (
    input  op_valid, funct, rs_data, rt_data, flush, div_dataOut,
    output stall, mf_data, div_signal, div_dataA, div_dataB, div_rst
  );

  modport master (
    output op_valid, funct, rs_data, rt_data, flush, div_dataOut,
    input  stall, mf_data, div_signal, div_dataA, div_dataB, div_rst
  );
endinterface

// File: rtl/hilo_divu_ctrl_hilo_regfile.sv
// rtl/hilo_divu_ctrl_hilo_regfile.sv - architectural HI/LO registers with capture-over-write priority
// Ports: i_clk, i_reset (async, active-low); i_we_hi/i_we_lo/i_wdata MTHI/MTLO writes;
//        i_cap_en/i_cap_data divider {remainder, quotient} capture;
//        i_rd_hi/i_rd_lo select o_rd_data; o_hi/o_lo register values.
module hilo_regfile (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_we_hi,
  input  logic        i_we_lo,
  input  logic [31:0] i_wdata,
  input  logic        i_cap_en,
  input  logic [63:0] i_cap_data,
  input  logic        i_rd_hi,
  input  logic        i_rd_lo,
  output logic [31:0] o_rd_data,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (i_cap_en) begin
      // Divider result wins over any same-cycle MTHI/MTLO.
      r_hi <= i_cap_data[63:32];
      r_lo <= i_cap_data[31:0];
    end else begin
      if (i_we_hi) r_hi <= i_wdata;
      if (i_we_lo) r_lo <= i_wdata;
    end
  end

  assign o_rd_data = i_rd_hi ? r_hi : (i_rd_lo ? r_lo : 32'd0);
  assign o_hi      = r_hi;
  assign o_lo      = r_lo;

  // The FSM only writes in IDLE and captures in BUSY, so a collision is a bug.
  a_no_write_on_capture: assert property (
    @(posedge i_clk) disable iff (!i_reset) !(i_cap_en && (i_we_hi || i_we_lo))
  );

endmodule

// File: rtl/hilo_divu_ctrl.sv
// rtl/hilo_divu_ctrl.sv - EX-stage controller sequencing the iterative unsigned divider and HI/LO
// Ports: i_clk; i_reset (async, active-low); bus (hilo_divu_if.slave: EX op/flush in,
//        stall/mf_data out, divider command/operands/reset out, divider result in);
//        o_hi/o_lo architectural HI/LO.
import hilo_divu_pkg::*;

module hilo_divu_ctrl #(
  parameter int DIV_ISSUE_CYCLES = DIV_ISSUE_CYCLES_DEF,
  parameter int DIV_RESULT_CYCLE = DIV_RESULT_CYCLE_DEF,
  parameter int CNT_W            = CNT_W_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hilo_divu_if.slave  bus,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [31:0]        r_div_a;
  logic [31:0]        r_div_b;

  logic               w_op_ok;
  logic               w_issue;
  logic               w_we_hi;
  logic               w_we_lo;
  logic               w_cap;
  logic               w_rd_hi;
  logic               w_rd_lo;
  logic               w_stall;
  logic               w_div_rst;
  logic [FUNCT_W-1:0] w_sig;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_div_a <= '0;
      r_div_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Operands only move on issue, so they stay fixed for all of BUSY.
      if (w_issue) begin
        r_div_a <= bus.rs_data;
        r_div_b <= bus.rt_data;
      end
    end
  end

  // A flush in IDLE kills whatever op EX is presenting.
  assign w_op_ok = bus.op_valid && !bus.flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    w_we_hi     = 1'b0;
    w_we_lo     = 1'b0;
    w_cap       = 1'b0;
    w_rd_hi     = 1'b0;
    w_rd_lo     = 1'b0;
    w_stall     = 1'b0;
    w_div_rst   = 1'b0;
    w_sig       = SIG_PAUSE;

    case (r_state)
      ST_INIT: begin
        // One-cycle divider clear, used after reset and after a flushed divide.
        w_stall     = 1'b1;
        w_div_rst   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end

      ST_IDLE: begin
        if (w_op_ok) begin
          case (bus.funct)
            FUNCT_DIVU: begin
              w_issue     = 1'b1;
              w_stall     = 1'b1;
              w_cnt_nxt   = CNT_W'(1);
              w_state_nxt = ST_BUSY;
            end
            FUNCT_MTHI: w_we_hi = 1'b1;
            FUNCT_MTLO: w_we_lo = 1'b1;
            FUNCT_MFHI: w_rd_hi = 1'b1;
            FUNCT_MFLO: w_rd_lo = 1'b1;
            default: ;
          endcase
        end
      end

      ST_BUSY: begin
        // EX ops are ignored here; the stalled pipeline re-presents them later.
        w_stall = 1'b1;
        if (r_cnt <= CNT_W'(DIV_ISSUE_CYCLES)) w_sig = FUNCT_DIVU;
        if (bus.flush) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_INIT;
        end else if (r_cnt >= CNT_W'(DIV_RESULT_CYCLE)) begin
          // >= rather than == so a corrupted counter still terminates.
          w_cap       = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_stall     = 1'b1;
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  hilo_regfile u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we_hi    (w_we_hi),
    .i_we_lo    (w_we_lo),
    .i_wdata    (bus.rs_data),
    .i_cap_en   (w_cap),
    .i_cap_data (bus.div_dataOut),
    .i_rd_hi    (w_rd_hi),
    .i_rd_lo    (w_rd_lo),
    .o_rd_data  (bus.mf_data),
    .o_hi       (o_hi),
    .o_lo       (o_lo)
  );

  assign bus.stall      = w_stall;
  assign bus.div_rst    = w_div_rst;
  assign bus.div_signal = w_sig;
  assign bus.div_dataA  = r_div_a;
  assign bus.div_dataB  = r_div_b;

endmodule

// File: tb/tb_hilo_divu_ctrl.sv
// tb/tb_hilo_divu_ctrl.sv - scoreboard bench for hilo_divu_ctrl with a behavioural divider
import hilo_divu_pkg::*;

module tb_hilo_divu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_chk = 0;
  int          n_err = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          d_cnt = 0;

  hilo_divu_if bus();

  hilo_divu_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  // Divider: valid result only after 34 consecutive DIVU cycles, junk before that.
  always @(posedge clk) begin
    if (bus.div_rst) begin
      d_cnt           <= 0;
      bus.div_dataOut <= '0;
    end else if (bus.div_signal == FUNCT_DIVU) begin
      d_cnt <= d_cnt + 1;
      if (d_cnt == 33) bus.div_dataOut <= ref_div(bus.div_dataA, bus.div_dataB);
      else             bus.div_dataOut <= 64'hBAD0_BAD1_BAD2_BAD3;
    end else begin
      d_cnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_div_rst"}, bus.div_rst, 1);
    check({tag, "_stall"},   bus.stall, 1);
    check({tag, "_signal"},  bus.div_signal, SIG_PAUSE);
    check({tag, "_hilo"},    {hi, lo}, 64'd0);
    check({tag, "_ab"},      {bus.div_dataA, bus.div_dataB}, 64'd0);
    check({tag, "_mf"},      bus.mf_data, 0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input int flush_cyc, input int rst_cyc);
    int n_stall;
    int n_sig;
    int n_rst;
    bit ab_ok;
    bit done;
    logic [63:0] got;
    n_stall = 0; n_sig = 0; n_rst = 0; ab_ok = 1'b1; done = 1'b0;
    if (rst_cyc == 0) begin
      if (flush_cyc == 0) begin
        sb.push_back(ref_div(a, b));
        m_hi = ref_div(a, b) >> 32;
        m_lo = ref_div(a, b) & 64'hFFFF_FFFF;
      end else begin
        sb.push_back({m_hi, m_lo});
      end
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.funct = FUNCT_DIVU; bus.rs_data = a; bus.rt_data = b;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.flush    = (i == flush_cyc);
        if (i == rst_cyc) begin
          rst_n = 1'b0;
          #1;
          check_reset_vals("mid_rst");
          m_hi = 32'd0; m_lo = 32'd0;
          @(posedge clk); #1;
          rst_n = 1'b1;
          repeat (2) @(posedge clk);
          return;
        end
      end
      @(negedge clk);
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      n_stall++;
      if (bus.div_signal == FUNCT_DIVU) n_sig++;
      if (bus.div_rst) n_rst++;
      else if (i > 0 && {bus.div_dataA, bus.div_dataB} !== {a, b}) ab_ok = 1'b0;
    end
    bus.flush = 1'b0;
    check("div_done", done, 1);
    check("div_stall_cycles", n_stall, (flush_cyc != 0) ? 12 : 37);
    check("div_signal_cycles", n_sig, (flush_cyc != 0) ? flush_cyc : 34);
    check("div_rst_pulses", n_rst, (flush_cyc != 0) ? 1 : 0);
    check("div_operands_held", ab_ok, 1);
    if (sb.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      got = {hi, lo};
      check("div_hilo", got, sb.pop_front());
    end
  endtask

  task automatic mt_mf(input bit sel_hi, input logic [31:0] val);
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.funct = sel_hi ? FUNCT_MTHI : FUNCT_MTLO; bus.rs_data = val;
    @(negedge clk);
    check("mt_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.funct = sel_hi ? FUNCT_MFHI : FUNCT_MFLO; bus.rs_data = 32'h0;
    @(negedge clk);
    check(sel_hi ? "mfhi_data" : "mflo_data", bus.mf_data, val);
    check("mf_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    if (sel_hi) m_hi = val; else m_lo = val;
  endtask

  initial begin
    int n_rst;
    int n_stall;
    bus.op_valid = 1'b0; bus.funct = '0; bus.rs_data = '0; bus.rt_data = '0; bus.flush = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");

    @(posedge clk); #1;
    rst_n = 1'b1;
    n_rst = 0; n_stall = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.div_rst) n_rst++;
      if (bus.stall) n_stall++;
    end
    check("init_div_rst_cycles", n_rst, 1);
    check("init_stall_cycles", n_stall, 1);
    check("init_hilo", {hi, lo}, 64'd0);

    run_div(32'd100, 32'd7, 0, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 0, 0);
    run_div(32'd9, 32'd3, 0, 0);

    mt_mf(1'b1, 32'hDEAD_BEEF);
    mt_mf(1'b0, 32'h1234_5678);

    // Flush in IDLE suppresses an MTHI.
    @(posedge clk); #1;
    bus.op_valid = 1'b1; bus.funct = FUNCT_MTHI; bus.rs_data = 32'h5555_AAAA; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("idle_flush_hi", hi, m_hi);

    run_div(32'd50, 32'd5, 10, 0);
    run_div(32'd50, 32'd5, 0, 0);
    run_div(32'd77, 32'd0, 0, 0);
    run_div(32'd77, 32'd0, 0, 20);
    run_div(32'd1000, 32'd33, 0, 0);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
